// File: rtl/ctrl_pkg.sv
// Shared opcode/funct encodings and FSM state encoding for the op_aut control path.
package ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [5:0] ALU_NOP = 6'h00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WARM = 3'd1,
    ST_RUN  = 3'd2,
    ST_HALT = 3'd3,
    ST_STEP = 3'd4,
    ST_TRAP = 3'd5
  } state_t;
endpackage

// File: rtl/op_decode.sv
// Combinational instruction decode: opcode/funct/zero to datapath selects.
// Illegal encodings decode to all-zero selects with legal=0.
module op_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       rd_mux_s,
  output logic       op2_mux_s,
  output logic [5:0] alu_funct,
  output logic       branch_mux_s,
  output logic       wr,
  output logic       legal,
  output logic       is_halt
);
  always_comb begin
    rd_mux_s     = 1'b0;
    op2_mux_s    = 1'b0;
    alu_funct    = ALU_NOP;
    branch_mux_s = 1'b0;
    wr           = 1'b0;
    legal        = 1'b0;
    is_halt      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == F_ADD || funct == F_SUB || funct == F_AND ||
            funct == F_OR  || funct == F_SLT) begin
          rd_mux_s  = 1'b1;
          alu_funct = funct;
          wr        = 1'b1;
          legal     = 1'b1;
        end
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        op2_mux_s = 1'b1;
        wr        = 1'b1;
        legal     = 1'b1;
        case (opcode)
          OP_SLTI: alu_funct = F_SLT;
          OP_ANDI: alu_funct = F_AND;
          OP_ORI:  alu_funct = F_OR;
          default: alu_funct = F_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        alu_funct    = F_SUB;
        branch_mux_s = (opcode == OP_BEQ) ? zero : ~zero;
        legal        = 1'b1;
      end
      OP_HALT: begin
        legal   = 1'b1;
        is_halt = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/op_ctrl.sv
// Run-control FSM for op_aut: start-up, run, halt, single-step and sticky trap.
// Decode outputs are same-cycle and forced to zero outside RUN/STEP.
module op_ctrl
  import ctrl_pkg::*;
#(
  parameter int STARTUP_CYCLES = 2,
  parameter int RETIRE_W       = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                step,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                pc_en,
  output logic                write,
  output logic                rd_mux_s,
  output logic                op2_mux_s,
  output logic [5:0]          alu_funct,
  output logic                branch_mux_s,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired
);
  localparam int WW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  state_t                r_state;
  logic [WW-1:0]         r_warm;
  logic [RETIRE_W-1:0]   r_retired;

  logic       w_exec;
  logic       w_rd_mux_s;
  logic       w_op2_mux_s;
  logic [5:0] w_alu_funct;
  logic       w_branch_mux_s;
  logic       w_wr;
  logic       w_legal;
  logic       w_is_halt;

  op_decode u_decode (
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .rd_mux_s     (w_rd_mux_s),
    .op2_mux_s    (w_op2_mux_s),
    .alu_funct    (w_alu_funct),
    .branch_mux_s (w_branch_mux_s),
    .wr           (w_wr),
    .legal        (w_legal),
    .is_halt      (w_is_halt)
  );

  // Reset drives the state to IDLE asynchronously, so every gated output drops with it.
  assign w_exec       = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign pc_en        = w_exec & w_legal & ~w_is_halt;
  assign write        = w_exec & w_wr;
  assign rd_mux_s     = w_exec & w_rd_mux_s;
  assign op2_mux_s    = w_exec & w_op2_mux_s;
  assign branch_mux_s = w_exec & w_branch_mux_s;
  assign alu_funct    = w_exec ? w_alu_funct : ALU_NOP;
  assign state        = r_state;
  assign retired      = r_retired;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_warm    <= '0;
      r_retired <= '0;
    end else begin
      if (pc_en) r_retired <= r_retired + RETIRE_W'(1);
      case (r_state)
        ST_IDLE: if (start) begin
          r_state <= ST_WARM;
          r_warm  <= '0;
        end
        ST_WARM: begin
          r_warm <= r_warm + WW'(1);
          if (r_warm == WW'(STARTUP_CYCLES - 1)) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!w_legal)                r_state <= ST_TRAP;
          else if (w_is_halt || stop)  r_state <= ST_HALT;
        end
        ST_HALT: begin
          if (step)       r_state <= ST_STEP;
          else if (start) r_state <= ST_RUN;
        end
        ST_STEP: r_state <= w_legal ? ST_HALT : ST_TRAP;
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_op_ctrl.sv
// Directed vector bench for op_ctrl: one table row per clock, plus reset and trap sequences.
module tb_op_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, stop = 1'b0, step = 1'b0;
  logic [5:0]  opcode = 6'h00, funct = 6'h20;
  logic        zero = 1'b0;
  logic        pc_en, write, rd_mux_s, op2_mux_s, branch_mux_s;
  logic [5:0]  alu_funct;
  logic [2:0]  state;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  op_ctrl #(.STARTUP_CYCLES(2), .RETIRE_W(32)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .step(step),
    .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .write(write), .rd_mux_s(rd_mux_s), .op2_mux_s(op2_mux_s),
    .alu_funct(alu_funct), .branch_mux_s(branch_mux_s), .state(state), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        start, stop, step;
    logic [5:0]  op, fn;
    logic        zero;
    logic [2:0]  st;
    logic        pc, wr, rd, op2;
    logic [5:0]  alu;
    logic        br;
    logic [31:0] ret;
  } vec_t;

  localparam logic [2:0] S_IDLE = 3'd0, S_WARM = 3'd1, S_RUN = 3'd2,
                         S_HALT = 3'd3, S_STEP = 3'd4, S_TRAP = 3'd5;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] ctl, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic [2:0] st, input logic [3:0] en,
                              input logic [5:0] alu, input logic br, input logic [31:0] ret);
    vec_t v;
    {v.start, v.stop, v.step} = ctl;
    v.op = op; v.fn = fn; v.zero = z; v.st = st;
    {v.pc, v.wr, v.rd, v.op2} = en;
    v.alu = alu; v.br = br; v.ret = ret;
    return v;
  endfunction

  function automatic logic [45:0] observed();
    return {state, pc_en, write, rd_mux_s, op2_mux_s, alu_funct, branch_mux_s, retired};
  endfunction

  task automatic check(input string name, input logic [45:0] act, input logic [45:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d en=%b alu=%h br=%b ret=%0d, want st=%0d en=%b alu=%h br=%b ret=%0d",
               name, act[45:43], act[42:39], act[38:33], act[32], act[31:0],
               exp[45:43], exp[42:39], exp[38:33], exp[32], exp[31:0]);
    end
  endtask

  function automatic logic [45:0] expv(input logic [2:0] st, input logic [3:0] en,
                                       input logic [5:0] alu, input logic br, input logic [31:0] ret);
    return {st, en, alu, br, ret};
  endfunction

  task automatic drive(input logic s, input logic p, input logic t,
                       input logic [5:0] op, input logic [5:0] fn, input logic z);
    @(negedge clock);
    start = s; stop = p; step = t; opcode = op; funct = fn; zero = z;
    #1;
  endtask

  initial begin
    // ctl = {start,stop,step}; en = {pc_en,write,rd_mux_s,op2_mux_s}; expectations are pre-edge.
    vecs.push_back(mk(3'b000, 6'h00, 6'h20, 0, S_IDLE, 4'b0000, 6'h00, 0, 0));
    vecs.push_back(mk(3'b100, 6'h00, 6'h20, 0, S_IDLE, 4'b0000, 6'h00, 0, 0));
    vecs.push_back(mk(3'b000, 6'h00, 6'h20, 0, S_WARM, 4'b0000, 6'h00, 0, 0));
    vecs.push_back(mk(3'b111, 6'h00, 6'h20, 0, S_WARM, 4'b0000, 6'h00, 0, 0));
    vecs.push_back(mk(3'b000, 6'h00, 6'h20, 0, S_RUN,  4'b1110, 6'h20, 0, 0));
    vecs.push_back(mk(3'b000, 6'h00, 6'h22, 0, S_RUN,  4'b1110, 6'h22, 0, 1));
    vecs.push_back(mk(3'b000, 6'h00, 6'h2A, 0, S_RUN,  4'b1110, 6'h2A, 0, 2));
    vecs.push_back(mk(3'b000, 6'h04, 6'h00, 1, S_RUN,  4'b1000, 6'h22, 1, 3));
    vecs.push_back(mk(3'b000, 6'h04, 6'h00, 0, S_RUN,  4'b1000, 6'h22, 0, 4));
    vecs.push_back(mk(3'b000, 6'h05, 6'h00, 0, S_RUN,  4'b1000, 6'h22, 1, 5));
    vecs.push_back(mk(3'b000, 6'h08, 6'h00, 0, S_RUN,  4'b1101, 6'h20, 0, 6));
    vecs.push_back(mk(3'b000, 6'h0A, 6'h00, 0, S_RUN,  4'b1101, 6'h2A, 0, 7));
    vecs.push_back(mk(3'b000, 6'h0D, 6'h00, 0, S_RUN,  4'b1101, 6'h25, 0, 8));
    vecs.push_back(mk(3'b000, 6'h3F, 6'h00, 0, S_RUN,  4'b0000, 6'h00, 0, 9));
    vecs.push_back(mk(3'b000, 6'h08, 6'h00, 0, S_HALT, 4'b0000, 6'h00, 0, 9));
    vecs.push_back(mk(3'b001, 6'h08, 6'h00, 0, S_HALT, 4'b0000, 6'h00, 0, 9));
    vecs.push_back(mk(3'b000, 6'h08, 6'h00, 0, S_STEP, 4'b1101, 6'h20, 0, 9));
    vecs.push_back(mk(3'b101, 6'h08, 6'h00, 0, S_HALT, 4'b0000, 6'h00, 0, 10));
    vecs.push_back(mk(3'b000, 6'h3F, 6'h00, 0, S_STEP, 4'b0000, 6'h00, 0, 10));
    vecs.push_back(mk(3'b100, 6'h0C, 6'h00, 0, S_HALT, 4'b0000, 6'h00, 0, 10));
    vecs.push_back(mk(3'b010, 6'h0C, 6'h00, 0, S_RUN,  4'b1101, 6'h24, 0, 10));
    vecs.push_back(mk(3'b100, 6'h0C, 6'h00, 0, S_HALT, 4'b0000, 6'h00, 0, 11));
    vecs.push_back(mk(3'b000, 6'h00, 6'h24, 0, S_RUN,  4'b1110, 6'h24, 0, 11));
    vecs.push_back(mk(3'b000, 6'h00, 6'h25, 0, S_RUN,  4'b1110, 6'h25, 0, 12));
    vecs.push_back(mk(3'b000, 6'h00, 6'h21, 0, S_RUN,  4'b0000, 6'h00, 0, 13));
    vecs.push_back(mk(3'b101, 6'h08, 6'h00, 0, S_TRAP, 4'b0000, 6'h00, 0, 13));
    vecs.push_back(mk(3'b001, 6'h00, 6'h20, 0, S_TRAP, 4'b0000, 6'h00, 0, 13));

    #1;
    check("reset_hold", observed(), expv(S_IDLE, 4'b0000, 6'h00, 0, 0));
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].step, vecs[i].op, vecs[i].fn, vecs[i].zero);
      check($sformatf("vec%0d", i), observed(),
            expv(vecs[i].st, {vecs[i].pc, vecs[i].wr, vecs[i].rd, vecs[i].op2},
                 vecs[i].alu, vecs[i].br, vecs[i].ret));
    end

    // Asynchronous reset in the middle of a RUN cycle.
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    drive(1, 0, 0, 6'h00, 6'h20, 0);
    drive(0, 0, 0, 6'h00, 6'h20, 0);
    drive(0, 0, 0, 6'h00, 6'h20, 0);
    drive(0, 0, 0, 6'h00, 6'h20, 0);
    check("run_before_reset", observed(), expv(S_RUN, 4'b1110, 6'h20, 0, 0));
    drive(0, 0, 0, 6'h00, 6'h20, 0);
    check("run_count", observed(), expv(S_RUN, 4'b1110, 6'h20, 0, 1));
    #1 reset = 1'b0;
    #1;
    check("reset_mid_run", observed(), expv(S_IDLE, 4'b0000, 6'h00, 0, 0));
    @(negedge clock); reset = 1'b1;

    // Illegal opcode 3E from RUN is sticky until reset.
    drive(1, 0, 0, 6'h3E, 6'h00, 0);
    drive(0, 0, 0, 6'h3E, 6'h00, 0);
    drive(0, 0, 0, 6'h3E, 6'h00, 0);
    drive(0, 0, 0, 6'h3E, 6'h00, 0);
    check("illegal_in_run", observed(), expv(S_RUN, 4'b0000, 6'h00, 0, 0));
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 6'h00, 6'h20, 0);
      check($sformatf("trap_sticky%0d", i), observed(), expv(S_TRAP, 4'b0000, 6'h00, 0, 0));
    end
    #1 reset = 1'b0;
    #1;
    check("trap_reset", observed(), expv(S_IDLE, 4'b0000, 6'h00, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
